snoop_bus_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared snooping coherence bus. Each per-CPU cache controller raises a request carrying its bus message (read miss, write miss, invalidate) and block address. The arbiter grants one requester at a time and broadcasts the message to all caches. It collects snoop acknowledgements from every other cache, then signals completion to the owner. It sits between the CPU-side MSI state machines and the snoop-side state machines.

---
 rtl/coherence_bus_pkg.sv | 28 ++
 rtl/rr_priority_pick.sv | 30 +++
 rtl/snoop_bus_arbiter.sv | 116 +++++++++++
 tb/tb_snoop_bus_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coherence_bus_pkg.sv
// Shared encodings for the snooping coherence bus: bus messages,
// MSI line states and the bus arbiter sequencing states.
package coherence_bus_pkg;

    typedef enum logic [1:0] {
        MSG_READ_MISS  = 2'b00,
        MSG_WRITE_MISS = 2'b01,
        MSG_INVALIDATE = 2'b10,
        MSG_EMPTY      = 2'b11
    } bus_msg_e;

    typedef enum logic [1:0] {
        MSI_INVALID  = 2'b00,
        MSI_SHARED   = 2'b01,
        MSI_MODIFIED = 2'b10
    } msi_state_e;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_BUS  = 2'b01,
        ARB_DONE = 2'b10
    } arb_state_e;

    function automatic int src_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin selector: first set request strictly after last,
// searching upward with wrap-around.
module rr_priority_pick #(
    parameter int N     = 4,
    parameter int SRC_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [SRC_W-1:0] last,
    output logic [N-1:0]     onehot,
    output logic [SRC_W-1:0] index
);

    always_comb begin : pick
        int   j;
        logic found;
        j      = 0;
        found  = 1'b0;
        onehot = '0;
        index  = '0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(last) + k) % N;
            if (!found && req[j]) begin
                found     = 1'b1;
                onehot[j] = 1'b1;
                index     = SRC_W'(j);
            end
        end
    end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter and sequencer for the shared snooping bus:
// grants one cache, broadcasts its message, gathers snoop acks.
module snoop_bus_arbiter
    import coherence_bus_pkg::*;
#(
    parameter int NUM_CPUS    = 4,
    parameter int ADDR_W      = 8,
    parameter int ACK_TIMEOUT = 15,
    localparam int SRC_W      = src_width(NUM_CPUS)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_CPUS-1:0]        req,
    input  logic [2*NUM_CPUS-1:0]      req_msg,
    input  logic [ADDR_W*NUM_CPUS-1:0] req_addr,
    input  logic [NUM_CPUS-1:0]        snoop_ack,
    output logic [NUM_CPUS-1:0]        grant,
    output logic                       bus_valid,
    output logic [1:0]                 bus_msg,
    output logic [ADDR_W-1:0]          bus_addr,
    output logic [SRC_W-1:0]           bus_src,
    output logic [NUM_CPUS-1:0]        done,
    output logic                       bus_err
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [SRC_W-1:0] LAST_RST = SRC_W'(NUM_CPUS - 1);

    arb_state_e          state;
    logic [SRC_W-1:0]    last_grant;
    logic [NUM_CPUS-1:0] owner;
    logic [NUM_CPUS-1:0] ack_seen;
    logic [CNT_W-1:0]    cnt;

    logic [NUM_CPUS-1:0] pick_oh;
    logic [SRC_W-1:0]    pick_idx;
    logic [1:0]          msg_sel;
    logic [ADDR_W-1:0]   addr_sel;
    logic [NUM_CPUS-1:0] cov;
    logic                all_acked;

    rr_priority_pick #(
        .N     (NUM_CPUS),
        .SRC_W (SRC_W)
    ) u_pick (
        .req    (req),
        .last   (last_grant),
        .onehot (pick_oh),
        .index  (pick_idx)
    );

    // Only the selected slice is read, so X on other CPUs stays out.
    assign msg_sel  = req_msg[int'(pick_idx)*2 +: 2];
    assign addr_sel = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];

    assign cov       = ack_seen | (snoop_ack & ~owner);
    assign all_acked = &(cov | owner);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ARB_IDLE;
            last_grant <= LAST_RST;
            owner      <= '0;
            ack_seen   <= '0;
            cnt        <= '0;
            grant      <= '0;
            bus_valid  <= 1'b0;
            bus_msg    <= '0;
            bus_addr   <= '0;
            bus_src    <= '0;
            done       <= '0;
            bus_err    <= 1'b0;
        end else begin
            done    <= '0;
            bus_err <= 1'b0;
            unique case (state)
                ARB_IDLE: begin
                    if (|req) begin
                        owner    <= pick_oh;
                        bus_src  <= pick_idx;
                        bus_msg  <= msg_sel;
                        bus_addr <= addr_sel;
                        if (msg_sel == MSG_EMPTY) begin
                            state <= ARB_DONE;
                            done  <= pick_oh;
                        end else begin
                            state     <= ARB_BUS;
                            grant     <= pick_oh;
                            bus_valid <= 1'b1;
                        end
                    end
                end
                ARB_BUS: begin
                    ack_seen <= cov;
                    cnt      <= cnt + 1'b1;
                    if (all_acked || cnt >= CNT_LAST) begin
                        state     <= ARB_DONE;
                        grant     <= '0;
                        bus_valid <= 1'b0;
                        done      <= owner;
                        bus_err   <= ~all_acked;
                    end
                end
                ARB_DONE: begin
                    last_grant <= bus_src;
                    ack_seen   <= '0;
                    cnt        <= '0;
                    state      <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Self-checking bench for snoop_bus_arbiter (4 CPUs, 8-bit address).
module tb_snoop_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [7:0]  req_msg;
    logic [31:0] req_addr;
    logic [3:0]  snoop_ack;
    logic [3:0]  grant;
    logic        bus_valid;
    logic [1:0]  bus_msg;
    logic [7:0]  bus_addr;
    logic [1:0]  bus_src;
    logic [3:0]  done;
    logic        bus_err;

    snoop_bus_arbiter #(
        .NUM_CPUS    (4),
        .ADDR_W      (8),
        .ACK_TIMEOUT (15)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .req_msg   (req_msg),
        .req_addr  (req_addr),
        .snoop_ack (snoop_ack),
        .grant     (grant),
        .bus_valid (bus_valid),
        .bus_msg   (bus_msg),
        .bus_addr  (bus_addr),
        .bus_src   (bus_src),
        .done      (done),
        .bus_err   (bus_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         src;
        logic [1:0] msg;
        logic [7:0] addr;
        logic       err;
        int         bus_cyc;
    } exp_t;

    typedef struct {
        int         cpu;
        logic [1:0] msg;
        logic [7:0] addr;
        logic [3:0] ack;
        logic       err;
        int         bus_cyc;
    } vec_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int src, input logic [1:0] msg,
                        input logic [7:0] addr, input logic err,
                        input int bc);
        exp_t e;
        e.src = src; e.msg = msg; e.addr = addr;
        e.err = err; e.bus_cyc = bc;
        sb.push_back(e);
    endtask

    // Monitor: pops one expectation per done pulse.
    int         vcnt;
    logic [1:0] cmsg;
    logic [7:0] caddr;
    logic [1:0] csrc;
    bit         gok;

    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            vcnt = 0;
            gok  = 1'b1;
        end else begin
            if (bus_valid) begin
                vcnt++;
                cmsg  = bus_msg;
                caddr = bus_addr;
                csrc  = bus_src;
                if (grant != 4'(1 << bus_src)) gok = 1'b0;
            end
            if (done != 4'b0) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("done_onehot", 32'(done), 32'(1 << e.src));
                    check("bus_err", 32'(bus_err), 32'(e.err));
                    check("bus_cycles", vcnt, e.bus_cyc);
                    check("grant_at_done", 32'(grant), 32'h0);
                    if (e.bus_cyc > 0) begin
                        check("bus_msg", 32'(cmsg), 32'(e.msg));
                        check("bus_addr", 32'(caddr), 32'(e.addr));
                        check("bus_src", 32'(csrc), e.src);
                        check("grant_match", 32'(gok), 32'h1);
                    end
                end
                vcnt = 0;
                gok  = 1'b1;
            end else if (bus_err) begin
                check("stray_bus_err", 32'(bus_err), 32'h0);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clock);
            n++;
        end
        check("txn_pending", sb.size(), 0);
        sb.delete();
        @(negedge clock);
    endtask

    task automatic drive_one(input int cpu, input logic [1:0] msg,
                             input logic [7:0] addr);
        req_msg  = '0;
        req_addr = '0;
        req_msg[2*cpu +: 2]  = msg;
        req_addr[8*cpu +: 8] = addr;
        req = 4'(1 << cpu);
    endtask

    task automatic serve_pair(input int a, input int b);
        bit seen;
        req_msg  = '0;
        req_addr = '0;
        req_addr[8*a +: 8] = 8'(8'h10 + a);
        req_addr[8*b +: 8] = 8'(8'h10 + b);
        snoop_ack = 4'hF;
        req = 4'((1 << a) | (1 << b));
        push(a, 2'b00, 8'(8'h10 + a), 1'b0, 1);
        push(b, 2'b00, 8'(8'h10 + b), 1'b0, 1);
        @(negedge clock);
        check("pair_first_grant", 32'(grant), 32'(1 << a));
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (grant == 4'(1 << b)) seen = 1'b1;
        end
        check("pair_second_grant", 32'(seen), 32'h1);
        req = '0;
        wait_idle();
        snoop_ack = '0;
    endtask

    vec_t vecs[7];

    initial begin
        int order_n, last_cyc;
        logic [3:0] prevg;

        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, last_cyc;
        logic [3:0] prevg;

        vecs[0] = '{1, 2'b00, 8'h3C, 4'b1101, 1'b0, 1};
        vecs[1] = '{2, 2'b10, 8'h81, 4'b0111, 1'b1, 15};
        vecs[2] = '{0, 2'b01, 8'h55, 4'b1110, 1'b0, 1};
        vecs[3] = '{3, 2'b11, 8'hAA, 4'b0000, 1'b0, 0};
        vecs[4] = '{3, 2'b10, 8'hF0, 4'b0111, 1'b0, 1};
        vecs[5] = '{0, 2'b00, 8'h01, 4'b1111, 1'b0, 1};
        vecs[6] = '{1, 2'b01, 8'h7E, 4'b0000, 1'b1, 15};

        reset = 1'b1;
        req = '0; req_msg = '0; req_addr = '0; snoop_ack = '0;
        repeat (2) @(negedge clock);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_valid", 32'(bus_valid), 32'h0);
        check("rst_bus", 32'({bus_msg, bus_addr, bus_src}), 32'h0);
        check("rst_done_err", 32'({done, bus_err}), 32'h0);
        reset = 1'b0;
        @(negedge clock);

        // Table: one requester each; req dropped once granted.
        for (int v = 0; v < 7; v++) begin
            drive_one(vecs[v].cpu, vecs[v].msg, vecs[v].addr);
            snoop_ack = vecs[v].ack;
            push(vecs[v].cpu, vecs[v].msg, vecs[v].addr,
                 vecs[v].err, vecs[v].bus_cyc);
            @(negedge clock);
            if (vecs[v].msg == 2'b11) begin
                check("empty_done", 32'(done), 32'(1 << vecs[v].cpu));
                check("empty_valid", 32'(bus_valid), 32'h0);
            end else begin
                check("vec_grant", 32'(grant), 32'(1 << vecs[v].cpu));
            end
            req = '0;
            wait_idle();
            snoop_ack = '0;
        end

        // Reset mid-transaction aborts with no done pulse.
        drive_one(1, 2'b00, 8'h10);
        @(negedge clock);
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("abort_grant", 32'(grant), 32'h0);
        check("abort_valid", 32'(bus_valid), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        req = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        serve_pair(0, 1);

        // Full contention: rotation 0,1,2,3,0 at 3-cycle spacing.
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        req_msg   = '0;
        req_addr  = {8'h33, 8'h22, 8'h11, 8'h00};
        snoop_ack = 4'hF;
        req       = 4'hF;
        for (int k = 0; k < 5; k++)
            push(k % 4, 2'b00, 8'(8'h11 * (k % 4)), 1'b0, 1);
        n = 0;
        last_cyc = 0;
        prevg = '0;
        for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
            @(negedge clock);
            if (grant != 4'b0 && prevg == 4'b0) begin
                check("rr_order", 32'(grant), 32'(1 << (n % 4)));
                if (n > 0) check("rr_spacing", cyc - last_cyc, 3);
                last_cyc = cyc;
                n++;
                if (n == 5) req = '0;
            end
            prevg = grant;
        end
        check("rr_grants", n, 5);
        req = '0;
        wait_idle();
        snoop_ack = '0;

        // Staggered ack pulses with owner CPU2.
        drive_one(2, 2'b01, 8'h42);
        push(2, 2'b01, 8'h42, 1'b0, 5);
        @(negedge clock);
        check("stag_grant", 32'(grant), 32'h4);
        req = '0;
        snoop_ack = 4'b0010;
        @(negedge clock) snoop_ack = 4'b0000;
        @(negedge clock) snoop_ack = 4'b0001;
        @(negedge clock) snoop_ack = 4'b0000;
        @(negedge clock) snoop_ack = 4'b1000;
        @(negedge clock) snoop_ack = 4'b0000;
        wait_idle();

        // Empty message from CPU3 still takes its turn.
        drive_one(3, 2'b11, 8'h99);
        push(3, 2'b11, 8'h99, 1'b0, 0);
        @(negedge clock);
        check("empty3_done", 32'(done), 32'h8);
        check("empty3_valid", 32'(bus_valid), 32'h0);
        req = '0;
        wait_idle();
        serve_pair(0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
